// File: rtl/bus_rr_arbiter_if.sv
// bus_rr_arbiter_if: request side and shared register bus
// seen by the round-robin bus arbiter.
interface bus_rr_arbiter_if #(
    parameter int g_NUM_MASTERS = 4
);
    logic [g_NUM_MASTERS-1:0]    i_Req;
    logic [g_NUM_MASTERS-1:0]    i_Wr_Rd_n;
    logic [16*g_NUM_MASTERS-1:0] i_Addr;
    logic [16*g_NUM_MASTERS-1:0] i_Wr_Data;
    logic [g_NUM_MASTERS-1:0]    o_Ack;
    logic [15:0]                 o_Rd_Data;
    logic                        o_Timeout;
    logic                        o_Busy;
    logic                        o_Bus_CS;
    logic                        o_Bus_Wr_Rd_n;
    logic [15:0]                 o_Bus_Addr8;
    logic [15:0]                 o_Bus_Wr_Data;
    logic [15:0]                 i_Bus_Rd_Data;
    logic                        i_Bus_Rd_DV;

    modport slave (
        input  i_Req, i_Wr_Rd_n, i_Addr, i_Wr_Data,
        input  i_Bus_Rd_Data, i_Bus_Rd_DV,
        output o_Ack, o_Rd_Data, o_Timeout, o_Busy,
        output o_Bus_CS, o_Bus_Wr_Rd_n,
        output o_Bus_Addr8, o_Bus_Wr_Data
    );

    modport master (
        output i_Req, i_Wr_Rd_n, i_Addr, i_Wr_Data,
        output i_Bus_Rd_Data, i_Bus_Rd_DV,
        input  o_Ack, o_Rd_Data, o_Timeout, o_Busy,
        input  o_Bus_CS, o_Bus_Wr_Rd_n,
        input  o_Bus_Addr8, o_Bus_Wr_Data
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin arbiter sharing one register bus
// between several masters, with a read-data timeout.
module bus_rr_arbiter #(
    parameter int g_NUM_MASTERS = 4,
    parameter int g_TIMEOUT     = 15
) (
    input logic             i_Bus_Clk,
    input logic             i_Bus_Rst_L,
    bus_rr_arbiter_if.slave bus
);
    localparam int IW = (g_NUM_MASTERS > 1) ?
                        $clog2(g_NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE, ISSUE, WAIT_RD, ACK
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [IW-1:0]            gnt_q, gnt_d;
    logic [IW-1:0]            ptr_q, ptr_d;
    logic [IW-1:0]            pick;
    logic                     pick_vld;
    logic [g_NUM_MASTERS-1:0] ack_d;
    logic                     cs_d, wr_d, tmo_d, busy_d;
    logic [15:0]              addr_d, wdata_d, rdata_d;

    // First requester at or after the priority pointer, wrapping.
    always_comb begin
        int j;
        j        = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = g_NUM_MASTERS - 1; i >= 0; i--) begin
            j = (int'(ptr_q) + i) % g_NUM_MASTERS;
            if (bus.i_Req[j]) begin
                pick     = IW'(j);
                pick_vld = 1'b1;
            end
        end
    end

    // Next state and next value of every registered output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        cs_d    = 1'b0;
        tmo_d   = 1'b0;
        wr_d    = bus.o_Bus_Wr_Rd_n;
        addr_d  = bus.o_Bus_Addr8;
        wdata_d = bus.o_Bus_Wr_Data;
        rdata_d = bus.o_Rd_Data;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = ISSUE;
                    gnt_d   = pick;
                    ptr_d   = (int'(pick) == g_NUM_MASTERS - 1) ?
                              '0 : pick + 1'b1;
                    cs_d    = 1'b1;
                    wr_d    = bus.i_Wr_Rd_n[pick];
                    addr_d  = bus.i_Addr[16*int'(pick) +: 16];
                    wdata_d = bus.i_Wr_Data[16*int'(pick) +: 16];
                end
            end
            ISSUE: begin
                if (bus.o_Bus_Wr_Rd_n) begin
                    state_d      = ACK;
                    ack_d[gnt_q] = 1'b1;
                end else begin
                    state_d = WAIT_RD;
                    cnt_d   = '0;
                end
            end
            WAIT_RD: begin
                if (bus.i_Bus_Rd_DV) begin
                    state_d      = ACK;
                    ack_d[gnt_q] = 1'b1;
                    rdata_d      = bus.i_Bus_Rd_Data;
                end else if (cnt_q == 8'(g_TIMEOUT - 1)) begin
                    state_d      = ACK;
                    ack_d[gnt_q] = 1'b1;
                    rdata_d      = 16'hDEAD;
                    tmo_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction.
    always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
        if (!i_Bus_Rst_L) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            gnt_q             <= '0;
            ptr_q             <= '0;
            bus.o_Ack         <= '0;
            bus.o_Rd_Data     <= '0;
            bus.o_Timeout     <= 1'b0;
            bus.o_Busy        <= 1'b0;
            bus.o_Bus_CS      <= 1'b0;
            bus.o_Bus_Wr_Rd_n <= 1'b0;
            bus.o_Bus_Addr8   <= '0;
            bus.o_Bus_Wr_Data <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            gnt_q             <= gnt_d;
            ptr_q             <= ptr_d;
            bus.o_Ack         <= ack_d;
            bus.o_Rd_Data     <= rdata_d;
            bus.o_Timeout     <= tmo_d;
            bus.o_Busy        <= busy_d;
            bus.o_Bus_CS      <= cs_d;
            bus.o_Bus_Wr_Rd_n <= wr_d;
            bus.o_Bus_Addr8   <= addr_d;
            bus.o_Bus_Wr_Data <= wdata_d;
        end
    end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed and randomized checks of the
// round-robin bus arbiter against a transaction-level model.
module tb_bus_rr_arbiter;
    localparam int N  = 4;
    localparam int TO = 15;

    logic r_Bus_Clk   = 1'b0;
    logic r_Bus_Rst_L = 1'b0;
    int   n_checks    = 0;
    int   n_errors    = 0;
    int   m_ptr       = 0;

    bit          ob_got_cs, ob_got_ack, ob_cs_wr, ob_tmo;
    int          ob_cs_wait, ob_k, ob_extra;
    logic [15:0] ob_addr, ob_wd, ob_rd;
    logic [N-1:0] ob_ack;

    bus_rr_arbiter_if #(.g_NUM_MASTERS(N)) bus ();

    bus_rr_arbiter #(
        .g_NUM_MASTERS(N),
        .g_TIMEOUT    (TO)
    ) dut (
        .i_Bus_Clk  (r_Bus_Clk),
        .i_Bus_Rst_L(r_Bus_Rst_L),
        .bus        (bus)
    );

    always #5 r_Bus_Clk = ~r_Bus_Clk;

    task automatic tick();
        @(posedge r_Bus_Clk);
        #1;
    endtask

    function automatic logic [55:0] outs();
        return {bus.o_Ack, bus.o_Rd_Data, bus.o_Timeout,
                bus.o_Busy, bus.o_Bus_CS, bus.o_Bus_Wr_Rd_n,
                bus.o_Bus_Addr8, bus.o_Bus_Wr_Data};
    endfunction

    // Round-robin rule: first requester from ptr upward, wrapping.
    function automatic int rr_pick(logic [N-1:0] req, int ptr);
        for (int i = 0; i < N; i++)
            if (req[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    // Clocks from the CS cycle to the ack cycle.
    function automatic int exp_lat(bit wr, int d);
        if (wr) return 1;
        if (d >= 1 && d <= TO) return d + 1;
        return TO + 1;
    endfunction

    function automatic logic [N-1:0] onehot(int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic set_master(input int m, input bit on,
                              input bit wr, input logic [15:0] a,
                              input logic [15:0] wd);
        bus.i_Req[m]            = on;
        bus.i_Wr_Rd_n[m]        = wr;
        bus.i_Addr[16*m +: 16]    = a;
        bus.i_Wr_Data[16*m +: 16] = wd;
    endtask

    // Waits for the CS pulse, then drives DV d clocks after it
    // (d == 0: never) and waits for the ack; leaves us in the ack cycle.
    task automatic run_txn(input int d, input logic [15:0] dvd,
                           input bit drop);
        ob_got_cs  = 0;
        ob_got_ack = 0;
        ob_cs_wait = 0;
        ob_k       = 0;
        ob_extra   = 0;
        ob_ack     = '0;
        for (int i = 1; i <= 12 && !ob_got_cs; i++) begin
            tick();
            if (bus.o_Bus_CS) begin
                ob_got_cs  = 1;
                ob_cs_wait = i;
                ob_addr    = bus.o_Bus_Addr8;
                ob_wd      = bus.o_Bus_Wr_Data;
                ob_cs_wr   = bus.o_Bus_Wr_Rd_n;
            end
        end
        if (ob_got_cs && drop) bus.i_Req = '0;
        for (int k = 1; k <= 30 && ob_got_cs && !ob_got_ack; k++) begin
            tick();
            if (bus.o_Bus_CS) ob_extra++;
            if (|bus.o_Ack) begin
                ob_got_ack = 1;
                ob_k       = k;
                ob_ack     = bus.o_Ack;
                ob_rd      = bus.o_Rd_Data;
                ob_tmo     = bus.o_Timeout;
            end else begin
                bus.i_Bus_Rd_DV   = (k == d);
                bus.i_Bus_Rd_Data = dvd;
            end
        end
        bus.i_Bus_Rd_DV = 1'b0;
    endtask

    task automatic test_reset();
        r_Bus_Rst_L = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (outs() !== '0) begin
            n_errors++;
            $display("FAIL reset_outs: got %h want 0", outs());
        end
        r_Bus_Rst_L = 1'b1;
        m_ptr = 0;
        tick();
        n_checks++;
        if (outs() !== '0) begin
            n_errors++;
            $display("FAIL post_reset_idle: got %h want 0", outs());
        end
    endtask

    task automatic test_write();
        int g;
        set_master(2, 1, 1, 16'h0000, 16'h0001);
        g = rr_pick(bus.i_Req, m_ptr);
        run_txn(0, 16'h0, 0);
        bus.i_Req = '0;
        m_ptr = (g + 1) % N;
        n_checks++;
        if (!ob_got_cs || ob_cs_wait != 1) begin
            n_errors++;
            $display("FAIL wr_cs_lat: got %0d/%0d want 1/1",
                     ob_got_cs, ob_cs_wait);
        end
        n_checks++;
        if ({ob_cs_wr, ob_addr, ob_wd} !== {1'b1, 16'h0000, 16'h0001}) begin
            n_errors++;
            $display("FAIL wr_cs_fields: got %b %h %h want 1 0000 0001",
                     ob_cs_wr, ob_addr, ob_wd);
        end
        n_checks++;
        if (ob_ack !== onehot(g) || ob_k != 1 || ob_tmo !== 1'b0) begin
            n_errors++;
            $display("FAIL wr_ack: got %b k=%0d tmo=%b want %b k=1 tmo=0",
                     ob_ack, ob_k, ob_tmo, onehot(g));
        end
        tick();
        n_checks++;
        if (bus.o_Busy !== 1'b0 || bus.o_Ack !== '0 || ob_extra != 0) begin
            n_errors++;
            $display("FAIL wr_end: got busy=%b ack=%b extra_cs=%0d want 0 0 0",
                     bus.o_Busy, bus.o_Ack, ob_extra);
        end
    endtask

    task automatic test_read();
        int g;
        set_master(1, 1, 0, 16'h0002, 16'h0000);
        g = rr_pick(bus.i_Req, m_ptr);
        run_txn(3, 16'h0001, 1);
        m_ptr = (g + 1) % N;
        n_checks++;
        if ({ob_cs_wr, ob_addr} !== {1'b0, 16'h0002}) begin
            n_errors++;
            $display("FAIL rd_cs_fields: got %b %h want 0 0002",
                     ob_cs_wr, ob_addr);
        end
        n_checks++;
        if (ob_ack !== onehot(g) || ob_k != exp_lat(0, 3)) begin
            n_errors++;
            $display("FAIL rd_ack: got %b k=%0d want %b k=%0d",
                     ob_ack, ob_k, onehot(g), exp_lat(0, 3));
        end
        n_checks++;
        if (ob_rd !== 16'h0001 || ob_tmo !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_data: got %h tmo=%b want 0001 tmo=0",
                     ob_rd, ob_tmo);
        end
        tick();
    endtask

    task automatic test_stray_dv();
        int g;
        bus.i_Bus_Rd_DV   = 1'b1;
        bus.i_Bus_Rd_Data = 16'hBAD1;
        repeat (2) tick();
        n_checks++;
        if (bus.o_Rd_Data !== 16'h0001 || bus.o_Busy !== 1'b0) begin
            n_errors++;
            $display("FAIL stray_idle: got %h busy=%b want 0001 busy=0",
                     bus.o_Rd_Data, bus.o_Busy);
        end
        set_master(0, 1, 0, 16'h0040, 16'h0000);
        g = rr_pick(bus.i_Req, m_ptr);
        run_txn(2, 16'h5A5A, 0);
        bus.i_Req = '0;
        m_ptr = (g + 1) % N;
        n_checks++;
        if (ob_ack !== onehot(g) || ob_k != exp_lat(0, 2) ||
            ob_rd !== 16'h5A5A || ob_tmo !== 1'b0) begin
            n_errors++;
            $display("FAIL stray_read: got %b k=%0d %h tmo=%b want %b k=%0d 5a5a tmo=0",
                     ob_ack, ob_k, ob_rd, ob_tmo, onehot(g), exp_lat(0, 2));
        end
        tick();
    endtask

    task automatic test_timeout();
        int g;
        set_master(3, 1, 0, 16'h0077, 16'h0000);
        g = rr_pick(bus.i_Req, m_ptr);
        run_txn(0, 16'h0, 0);
        bus.i_Req = '0;
        m_ptr = (g + 1) % N;
        n_checks++;
        if (ob_ack !== onehot(g) || ob_k != TO + 1) begin
            n_errors++;
            $display("FAIL tmo_ack: got %b k=%0d want %b k=%0d",
                     ob_ack, ob_k, onehot(g), TO + 1);
        end
        n_checks++;
        if (ob_rd !== 16'hDEAD || ob_tmo !== 1'b1) begin
            n_errors++;
            $display("FAIL tmo_data: got %h tmo=%b want dead tmo=1",
                     ob_rd, ob_tmo);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int g;
        r_Bus_Rst_L = 1'b0;
        tick();
        r_Bus_Rst_L = 1'b1;
        m_ptr = 0;
        tick();
        for (int m = 0; m < N; m++)
            set_master(m, 1, 1, 16'h0100 + 16'(m), 16'h0);
        for (int t = 0; t < 5; t++) begin
            g = rr_pick(bus.i_Req, m_ptr);
            run_txn(0, 16'h0, 0);
            m_ptr = (g + 1) % N;
            n_checks++;
            if (ob_ack !== onehot(g) || ob_addr !== 16'h0100 + 16'(g) ||
                ob_cs_wait != ((t == 0) ? 1 : 2)) begin
                n_errors++;
                $display("FAIL rr_grant%0d: got %b %h wait=%0d want %b %h wait=%0d",
                         t, ob_ack, ob_addr, ob_cs_wait, onehot(g),
                         16'h0100 + 16'(g), (t == 0) ? 1 : 2);
            end
        end
        bus.i_Req = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        bit bad;
        set_master(1, 1, 0, 16'h0011, 16'h0);
        repeat (4) tick();
        n_checks++;
        if (bus.o_Busy !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_busy: got %b want 1", bus.o_Busy);
        end
        r_Bus_Rst_L = 1'b0;
        bus.i_Req   = '0;
        #1;
        n_checks++;
        if (outs() !== '0) begin
            n_errors++;
            $display("FAIL mid_async: got %h want 0", outs());
        end
        repeat (2) tick();
        r_Bus_Rst_L = 1'b1;
        m_ptr = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.o_Ack !== '0 || bus.o_Busy !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL mid_no_ack: got ack/busy activity want none");
        end
        set_master(3, 1, 1, 16'h0033, 16'hC0DE);
        run_txn(0, 16'h0, 0);
        bus.i_Req = '0;
        m_ptr = 0;
        n_checks++;
        if (ob_ack !== 4'b1000 || ob_k != 1 || ob_cs_wait != 1 ||
            {ob_addr, ob_wd} !== {16'h0033, 16'hC0DE}) begin
            n_errors++;
            $display("FAIL mid_restart: got %b k=%0d w=%0d %h %h want 1000 k=1 w=1 0033 c0de",
                     ob_ack, ob_k, ob_cs_wait, ob_addr, ob_wd);
        end
        tick();
    endtask

    task automatic test_random();
        int g, d, exp_wait, ek;
        bit wr;
        logic [15:0] a, wd, dvd, erd;
        exp_wait = 1;
        for (int t = 0; t < 40; t++) begin
            if (bus.i_Req == '0)
                set_master(int'($urandom_range(0, N - 1)), 1,
                           1'($urandom), 16'($urandom), 16'($urandom));
            g   = rr_pick(bus.i_Req, m_ptr);
            wr  = bus.i_Wr_Rd_n[g];
            a   = bus.i_Addr[16*g +: 16];
            wd  = bus.i_Wr_Data[16*g +: 16];
            d   = int'($urandom_range(0, 20));
            dvd = 16'($urandom);
            run_txn(d, dvd, 0);
            ek  = exp_lat(wr, d);
            erd = (d >= 1 && d <= TO) ? dvd : 16'hDEAD;
            n_checks++;
            if (!ob_got_cs || ob_cs_wait != exp_wait ||
                {ob_cs_wr, ob_addr, ob_wd} !== {wr, a, wd}) begin
                n_errors++;
                $display("FAIL rnd_cs%0d: got w=%0d %b %h %h want w=%0d %b %h %h",
                         t, ob_cs_wait, ob_cs_wr, ob_addr, ob_wd,
                         exp_wait, wr, a, wd);
            end
            n_checks++;
            if (ob_ack !== onehot(g) || ob_k != ek) begin
                n_errors++;
                $display("FAIL rnd_ack%0d: got %b k=%0d want %b k=%0d",
                         t, ob_ack, ob_k, onehot(g), ek);
            end
            if (!wr) begin
                n_checks++;
                if (ob_rd !== erd || ob_tmo !== (erd == 16'hDEAD &&
                    !(d >= 1 && d <= TO) ? 1'b1 : 1'b0)) begin
                    n_errors++;
                    $display("FAIL rnd_rd%0d: got %h tmo=%b want %h d=%0d",
                             t, ob_rd, ob_tmo, erd, d);
                end
            end
            m_ptr    = (g + 1) % N;
            exp_wait = 2;
            set_master(g, 1'($urandom), 1'($urandom),
                       16'($urandom), 16'($urandom));
            for (int m = 0; m < N; m++)
                if (!bus.i_Req[m] && $urandom_range(0, 2) == 0)
                    set_master(m, 1, 1'($urandom),
                               16'($urandom), 16'($urandom));
        end
        bus.i_Req = '0;
        repeat (2) tick();
    endtask

    initial begin
        bus.i_Req         = '0;
        bus.i_Wr_Rd_n     = '0;
        bus.i_Addr        = '0;
        bus.i_Wr_Data     = '0;
        bus.i_Bus_Rd_Data = '0;
        bus.i_Bus_Rd_DV   = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_stray_dv();
        test_timeout();
        test_round_robin();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bus_rr_arbiter.md
BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 The block SHALL have parameter g_NUM_MASTERS, default 4, giving the number of requesting masters (2..8).
REQ-002 The block SHALL have parameter g_TIMEOUT, default 15, giving the maximum read wait in clocks (1..255).
REQ-003 The block SHALL have port i_Bus_Clk  in  1  bus clock (the only clock).
REQ-004 The block SHALL have port i_Bus_Rst_L  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_Req  in  g_NUM_MASTERS  per-master transaction request, held until ack.
REQ-006 The block SHALL have port i_Wr_Rd_n  in  g_NUM_MASTERS  per-master direction: 1 write, 0 read.
REQ-007 The block SHALL have port i_Addr  in  16*g_NUM_MASTERS  per-master address; master n in bits [16n+15:16n].
REQ-008 The block SHALL have port i_Wr_Data  in  16*g_NUM_MASTERS  per-master write data, same packing as i_Addr.
REQ-009 The block SHALL have port o_Ack  out  g_NUM_MASTERS  one-cycle completion pulse to the granted master.
REQ-010 The block SHALL have port o_Rd_Data  out  16  read data, valid while o_Ack is high.
REQ-011 The block SHALL have port o_Timeout  out  1  read timed out, valid while o_Ack is high.
REQ-012 The block SHALL have port o_Busy  out  1  high in every state except IDLE.
REQ-013 The block SHALL have ports o_Bus_CS, o_Bus_Wr_Rd_n (out 1), o_Bus_Addr8, o_Bus_Wr_Data (out 16) driving the shared register bus.
REQ-014 The block SHALL have ports i_Bus_Rd_Data (in 16) and i_Bus_Rd_DV (in 1) returning slave read data.

Function
REQ-015 The block SHALL implement FSM states IDLE, ISSUE, WAIT_RD and ACK, all outputs registered.
REQ-016 In IDLE with any i_Req bit high, the block SHALL select one master round-robin, latch its direction, address and write data, and go to ISSUE.
REQ-017 Round-robin SHALL give highest priority to master (last granted + 1) mod g_NUM_MASTERS; after reset master 0 has highest priority.
REQ-018 In ISSUE, o_Bus_CS SHALL be high for exactly one clock with the latched fields on the bus, then go to ACK for writes or WAIT_RD for reads.
REQ-019 o_Bus_Addr8, o_Bus_Wr_Data and o_Bus_Wr_Rd_n SHALL hold their latched values from ISSUE until the next ISSUE.
REQ-020 In WAIT_RD, i_Bus_Rd_DV high SHALL capture i_Bus_Rd_Data into o_Rd_Data and go to ACK with o_Timeout low.
REQ-021 In WAIT_RD, if g_TIMEOUT clocks elapse without i_Bus_Rd_DV, the block SHALL go to ACK with o_Rd_Data = 16'hDEAD and o_Timeout high.
REQ-022 i_Bus_Rd_DV outside WAIT_RD SHALL be ignored.
REQ-023 In ACK, exactly the granted o_Ack bit SHALL be high for one clock, then the FSM returns to IDLE.
REQ-024 Write latency SHALL be: request sampled at edge k, CS high in cycle k+1, ack in cycle k+2.
REQ-025 Dropping i_Req after grant SHALL NOT abort the transaction; i_Req still high in IDLE after ack SHALL count as a new request.
REQ-026 The minimum spacing between consecutive CS pulses SHALL be 3 clocks (IDLE, ISSUE, ACK).

Reset
REQ-027 While i_Bus_Rst_L is low, the block SHALL be in IDLE with all outputs 0 and the round-robin pointer at master 0.
REQ-028 Reset asserted mid-transaction SHALL abort it with no o_Ack; after release the block SHALL restart from IDLE.

Verification
REQ-029 Test: master 2 writes addr 16'h0000, data 16'h0001 -> one CS with those values, o_Ack[2] two clocks after the request is sampled, o_Timeout 0.
REQ-030 Test: master 1 reads 16'h0002; the slave returns DV with 16'h0001 three clocks after CS -> o_Ack[1] with o_Rd_Data 16'h0001.
REQ-031 Test: all four masters request continuously after reset -> grant order 0,1,2,3,0 with no master granted twice in a row.
REQ-032 Test: read with DV never asserted -> ack after 15 WAIT_RD clocks with o_Rd_Data 16'hDEAD and o_Timeout 1.
REQ-033 Test: reset pulsed while in WAIT_RD -> no ack, all outputs 0; the next request from master 3 completes normally.
REQ-034 Test: a stray DV during IDLE, followed by a read -> o_Rd_Data reflects only the DV that arrives in WAIT_RD.
